// File: rtl/pixel_readout_pkg.sv
// Shared state encoding, default timing and CDS clamp-subtract for the pixel readout sequencer.
package pixel_readout_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_EXPOSE,
    S_REF,
    S_SETTLE,
    S_CONVERT,
    S_HOLD,
    S_DONE
  } seq_state_t;

  localparam int DEF_N_ROWS   = 2;
  localparam int DEF_ADC_W    = 8;
  localparam int DEF_EXP_W    = 8;
  localparam int DEF_T_SETTLE = 2;
  localparam int DEF_T_CONV   = 3;

  // Operands are zero-extended into this width by the caller and truncated back.
  localparam int CDS_MAX_W = 32;

  function automatic logic [CDS_MAX_W-1:0] cds_sub(input logic [CDS_MAX_W-1:0] sig,
                                                   input logic [CDS_MAX_W-1:0] ref_v);
    return (sig > ref_v) ? (sig - ref_v) : '0;
  endfunction

endpackage

// File: rtl/seq_phase_timer.sv
// Loadable down-counter timing one sequencer phase; done is high while the count sits at 1.
module seq_phase_timer #(
  parameter int CNT_W = 9
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic             done
);

  logic [CNT_W-1:0] cnt_q;

  // Saturates at 1 so a finished phase never wraps.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else if (load) begin
      cnt_q <= load_val;
    end else if (cnt_q > CNT_W'(1)) begin
      cnt_q <= cnt_q - 1'b1;
    end
  end

  assign done = (cnt_q == CNT_W'(1));

endmodule

// File: rtl/pixel_readout_seq.sv
// Frame sequencer: exposure, per-row settle/convert/hold readout with valid/ready output.
// Define CDS_EN to add a reference conversion per row and output clamped (sig - ref).
module pixel_readout_seq
  import pixel_readout_pkg::*;
#(
  parameter int N_ROWS   = DEF_N_ROWS,
  parameter int ADC_W    = DEF_ADC_W,
  parameter int EXP_W    = DEF_EXP_W,
  parameter int T_SETTLE = DEF_T_SETTLE,
  parameter int T_CONV   = DEF_T_CONV
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        Init,
  input  logic [EXP_W-1:0]            exp_time,
  output logic                        Expose,
  output logic                        Erase,
  output logic [N_ROWS-1:0]           NRE,
  output logic                        ADC,
  input  logic [ADC_W-1:0]            adc_data,
  output logic [ADC_W-1:0]            pix_data,
  output logic [$clog2(N_ROWS):0]     pix_row,
  output logic                        pix_valid,
  input  logic                        pix_ready,
  output logic                        busy,
  output logic                        frame_done
);

  localparam int ROW_W   = $clog2(N_ROWS) + 1;
  localparam int MAX_ST  = (T_SETTLE > T_CONV) ? T_SETTLE : T_CONV;
  localparam int MAX_ALL = (MAX_ST > (1 << EXP_W)) ? MAX_ST : (1 << EXP_W);
  localparam int CNT_W   = $clog2(MAX_ALL) + 1;

`ifdef CDS_EN
  localparam seq_state_t ROW_START   = S_REF;
  localparam int         ROW_START_T = T_CONV;
`else
  localparam seq_state_t ROW_START   = S_SETTLE;
  localparam int         ROW_START_T = T_SETTLE;
`endif

  seq_state_t       state_q, state_d;
  logic [ROW_W-1:0] row_q, row_d;
  logic [ADC_W-1:0] pix_data_q;
  logic [ROW_W-1:0] pix_row_q;
  logic             tmr_load;
  logic [CNT_W-1:0] tmr_val;
  logic             tmr_done;
  logic             cap_sig;
`ifdef CDS_EN
  logic             cap_ref;
  logic [ADC_W-1:0] ref_q;
`endif

  seq_phase_timer #(.CNT_W(CNT_W)) u_timer (
    .clk      (clk),
    .reset    (reset),
    .load     (tmr_load),
    .load_val (tmr_val),
    .done     (tmr_done)
  );

  // Each phase transition reloads the shared timer with the next phase's length.
  always_comb begin
    state_d  = state_q;
    row_d    = row_q;
    tmr_load = 1'b0;
    tmr_val  = '0;
    cap_sig  = 1'b0;
`ifdef CDS_EN
    cap_ref  = 1'b0;
`endif
    unique case (state_q)
      S_IDLE: begin
        if (Init) begin
          state_d  = S_EXPOSE;
          tmr_load = 1'b1;
          tmr_val  = (exp_time == '0) ? CNT_W'(1) : CNT_W'(exp_time);
        end
      end
      S_EXPOSE: begin
        if (tmr_done) begin
          state_d  = ROW_START;
          row_d    = '0;
          tmr_load = 1'b1;
          tmr_val  = CNT_W'(ROW_START_T);
        end
      end
`ifdef CDS_EN
      S_REF: begin
        if (tmr_done) begin
          cap_ref  = 1'b1;
          state_d  = S_SETTLE;
          tmr_load = 1'b1;
          tmr_val  = CNT_W'(T_SETTLE);
        end
      end
`endif
      S_SETTLE: begin
        if (tmr_done) begin
          state_d  = S_CONVERT;
          tmr_load = 1'b1;
          tmr_val  = CNT_W'(T_CONV);
        end
      end
      S_CONVERT: begin
        if (tmr_done) begin
          cap_sig = 1'b1;
          state_d = S_HOLD;
        end
      end
      S_HOLD: begin
        if (pix_ready) begin
          if (row_q == ROW_W'(N_ROWS - 1)) begin
            state_d = S_DONE;
          end else begin
            row_d    = row_q + 1'b1;
            state_d  = ROW_START;
            tmr_load = 1'b1;
            tmr_val  = CNT_W'(ROW_START_T);
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      row_q      <= '0;
      pix_data_q <= '0;
      pix_row_q  <= '0;
`ifdef CDS_EN
      ref_q      <= '0;
`endif
    end else begin
      state_q <= state_d;
      row_q   <= row_d;
`ifdef CDS_EN
      if (cap_ref) begin
        ref_q <= adc_data;
      end
      if (cap_sig) begin
        pix_data_q <= ADC_W'(cds_sub(CDS_MAX_W'(adc_data), CDS_MAX_W'(ref_q)));
        pix_row_q  <= row_q;
      end
`else
      if (cap_sig) begin
        pix_data_q <= adc_data;
        pix_row_q  <= row_q;
      end
`endif
    end
  end

  // Moore outputs: decoded purely from state and row counter.
  always_comb begin
    Expose     = (state_q == S_EXPOSE);
    Erase      = (state_q == S_IDLE);
    ADC        = (state_q == S_CONVERT) || (state_q == S_REF);
    pix_valid  = (state_q == S_HOLD);
    busy       = (state_q != S_IDLE);
    frame_done = (state_q == S_DONE);
    NRE        = '1;
    if ((state_q == S_SETTLE) || (state_q == S_CONVERT)) begin
      for (int i = 0; i < N_ROWS; i++) begin
        if (row_q == ROW_W'(i)) begin
          NRE[i] = 1'b0;
        end
      end
    end
  end

  assign pix_data = pix_data_q;
  assign pix_row  = pix_row_q;

endmodule
